// File: rtl/ysyx_22041752_div_iter.sv
// Iterative restoring divider for the EX stage: RV64M DIV/DIVU/REM/REMU semantics,
// one quotient bit per cycle. The caller selects quotient or remainder and applies any
// word sign-extension itself.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         asynchronous reset, active-low
//   flush_i        synchronous pipeline flush, aborts any operation
//   div_valid_i    request, level-held by EX while a div/rem sits in EX
//   div_signed_i   1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
//   dividend_i     numerator, sampled on accept
//   divisor_i      denominator, sampled on accept
//   div_ready_o    high while idle (a request would be accepted)
//   out_valid_o    single-cycle pulse, quotient_o/remainder_o valid
//   quotient_o     registered quotient, held until the next completion
//   remainder_o    registered remainder, held until the next completion
module ysyx_22041752_div_iter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             div_valid_i,
  input  logic             div_signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             div_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam logic [WIDTH-1:0] One    = WIDTH'(1);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;       // dividend shifts out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  // Operand decode for the accept cycle.
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, overflow;

  assign sa       = div_signed_i & dividend_i[WIDTH-1];
  assign sb       = div_signed_i & divisor_i[WIDTH-1];
  // |most-negative| wraps to itself, which is the right magnitude read as unsigned.
  assign mag_a    = sa ? (~dividend_i + One) : dividend_i;
  assign mag_b    = sb ? (~divisor_i + One) : divisor_i;
  assign div_zero = (divisor_i == '0);
  assign overflow = div_signed_i & (dividend_i == MinNeg) & (divisor_i == '1);

  // One restoring step: shift {rem,quo} left and trial-subtract the divisor.
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH:0]   rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign trial   = {rem_q, quo_q[WIDTH-1]} - {2'b00, dvs_q};
  assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign ge      = ~trial[WIDTH+1];
  assign rem_n   = ge ? trial[WIDTH:0] : shifted;
  assign quo_n   = {quo_q[WIDTH-2:0], ge};
  assign quo_fix = qsign_q ? (~quo_n + One) : quo_n;
  assign rem_fix = rsign_q ? (~rem_n[WIDTH-1:0] + One) : rem_n[WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qsign_d     = qsign_q;
    rsign_d     = rsign_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    if (flush_i) begin
      // Aborted work is dropped; previously presented results stay put.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (div_valid_i) begin
            qsign_d = sa ^ sb;
            rsign_d = sa;
            cnt_d   = '0;
            if (div_zero) begin
              quotient_d  = '1;
              remainder_d = dividend_i;
              state_d     = StDone;
            end else if (overflow) begin
              quotient_d  = dividend_i;
              remainder_d = '0;
              state_d     = StDone;
            end else begin
              rem_d   = '0;
              quo_d   = mag_a;
              dvs_d   = mag_b;
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          rem_d = rem_n;
          quo_d = quo_n;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LastCnt) begin
            quotient_d  = quo_fix;
            remainder_d = rem_fix;
            state_d     = StDone;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      qsign_q     <= 1'b0;
      rsign_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      qsign_q     <= qsign_d;
      rsign_q     <= rsign_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign div_ready_o = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;

endmodule

// File: tb/tb_ysyx_22041752_div_iter.sv
module tb_ysyx_22041752_div_iter;

  localparam logic [63:0] MinNeg = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        div_valid = 1'b0;
  logic        div_signed = 1'b0;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        div_ready;
  logic        out_valid;
  logic [63:0] quotient;
  logic [63:0] remainder;

  int tests = 0;
  int fails = 0;

  ysyx_22041752_div_iter #(
    .WIDTH(64),
    .CNT_W(7)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .div_valid_i (div_valid),
    .div_signed_i(div_signed),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .div_ready_o (div_ready),
    .out_valid_o (out_valid),
    .quotient_o  (quotient),
    .remainder_o (remainder)
  );

  always #5 clk = ~clk;

  // Reference: RV64M division rules with plain arithmetic.
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic s,
                                output logic [63:0] q, output logic [63:0] r);
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s && a == MinNeg && b == '1) begin
      q = a;
      r = '0;
    end else if (s) begin
      sa = a;
      sb = b;
      q  = 64'(sa / sb);
      r  = 64'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one request (single-cycle div_valid), then watch 70 cycles. lat is the cycle
  // offset (accept cycle = 0) of the first out_valid, 0 if none.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                        output logic [63:0] q, output logic [63:0] r,
                        output int lat, output int pulses);
    lat    = 0;
    pulses = 0;
    q      = '0;
    r      = '0;
    @(negedge clk);
    dividend   = a;
    divisor    = b;
    div_signed = s;
    div_valid  = 1'b1;
    @(negedge clk);
    div_valid = 1'b0;
    dividend  = {$urandom, $urandom};
    divisor   = {$urandom, $urandom};
    for (int c = 1; c <= 70; c++) begin
      if (c > 1) @(negedge clk);
      if (out_valid) begin
        pulses++;
        if (lat == 0) begin
          lat = c;
          q   = quotient;
          r   = remainder;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (div_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: ready=%b valid=%b required ready=1 valid=0", div_ready, out_valid);
    end
    tests++;
    if (quotient !== '0 || remainder !== '0) begin
      fails++;
      $display("FAIL reset_data: q=%h r=%h required 0/0", quotient, remainder);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_timing();
    logic [63:0] q, r;
    int bad;
    bad = 0;
    q   = '0;
    r   = '0;
    @(negedge clk);
    dividend   = 64'd100;
    divisor    = 64'd7;
    div_signed = 1'b0;
    div_valid  = 1'b1;
    tests++;
    if (div_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_at_accept: got %b required 1", div_ready);
    end
    @(negedge clk);
    div_valid = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      if (c > 1) @(negedge clk);
      if (div_ready !== (c >= 66)) bad++;
      if (out_valid !== (c == 65)) bad++;
      if (c == 65) begin
        q = quotient;
        r = remainder;
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL udiv_timing: %0d cycle mismatches on ready/valid, required 0", bad);
    end
    tests++;
    if (q !== 64'd14 || r !== 64'd2) begin
      fails++;
      $display("FAIL udiv_100_7: q=%0d r=%0d required 14/2", q, r);
    end
  endtask

  task automatic test_signed_vectors();
    logic [63:0] q, r;
    int lat, pulses;
    run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, q, r, lat, pulses);
    tests++;
    if (q !== 64'hFFFF_FFFF_FFFF_FFFD || r !== '1 || lat != 65 || pulses != 1) begin
      fails++;
      $display("FAIL sdiv_m7_2: q=%h r=%h lat=%0d n=%0d required fffffffffffffffd/ffffffffffffffff/65/1",
               q, r, lat, pulses);
    end
    run_op(64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, q, r, lat, pulses);
    tests++;
    if (q !== 64'hFFFF_FFFF_FFFF_FFFD || r !== 64'd1 || lat != 65) begin
      fails++;
      $display("FAIL sdiv_7_m2: q=%h r=%h lat=%0d required fffffffffffffffd/1/65", q, r, lat);
    end
    run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, q, r, lat, pulses);
    tests++;
    if (q !== 64'h7FFF_FFFF_FFFF_FFFC || r !== 64'd1 || lat != 65) begin
      fails++;
      $display("FAIL udiv_big_2: q=%h r=%h lat=%0d required 7ffffffffffffffc/1/65", q, r, lat);
    end
  endtask

  task automatic test_special();
    logic [63:0] q, r;
    int lat, pulses;
    for (int s = 0; s < 2; s++) begin
      run_op(64'd5, 64'd0, s[0], q, r, lat, pulses);
      tests++;
      if (q !== '1 || r !== 64'd5 || lat != 1 || pulses != 1) begin
        fails++;
        $display("FAIL div_zero s=%0d: q=%h r=%h lat=%0d n=%0d required ffffffffffffffff/5/1/1",
                 s, q, r, lat, pulses);
      end
    end
    run_op(MinNeg, '1, 1'b1, q, r, lat, pulses);
    tests++;
    if (q !== MinNeg || r !== '0 || lat != 1 || pulses != 1) begin
      fails++;
      $display("FAIL overflow: q=%h r=%h lat=%0d n=%0d required 8000000000000000/0/1/1",
               q, r, lat, pulses);
    end
  endtask

  task automatic test_flush();
    logic [63:0] prev_q, prev_r, q, r;
    int early, first, pulses;
    early  = 0;
    first  = 0;
    pulses = 0;
    q      = '0;
    r      = '0;
    @(negedge clk);
    prev_q     = quotient;
    prev_r     = remainder;
    dividend   = 64'd1000;
    divisor    = 64'd3;
    div_signed = 1'b0;
    div_valid  = 1'b1;
    @(negedge clk);
    div_valid = 1'b0;
    for (int c = 2; c <= 30; c++) begin
      @(negedge clk);
      if (out_valid) early++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests++;
    if (div_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle: ready=%b valid=%b required 1/0", div_ready, out_valid);
    end
    tests++;
    if (quotient !== prev_q || remainder !== prev_r) begin
      fails++;
      $display("FAIL flush_hold: q=%h r=%h required %h/%h", quotient, remainder, prev_q, prev_r);
    end
    dividend  = 64'd9;
    divisor   = 64'd4;
    div_valid = 1'b1;
    @(negedge clk);
    div_valid = 1'b0;
    for (int c = 32; c <= 110; c++) begin
      if (c > 32) @(negedge clk);
      if (out_valid) begin
        pulses++;
        if (first == 0) begin
          first = c;
          q     = quotient;
          r     = remainder;
        end
      end
    end
    tests++;
    if (early != 0 || first != 96 || pulses != 1) begin
      fails++;
      $display("FAIL flush_timing: early=%0d first=%0d n=%0d required 0/96/1", early, first, pulses);
    end
    tests++;
    if (q !== 64'd2 || r !== 64'd1) begin
      fails++;
      $display("FAIL after_flush_9_4: q=%0d r=%0d required 2/1", q, r);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] q, r;
    int lat, pulses;
    @(negedge clk);
    dividend   = 64'd1000;
    divisor    = 64'd3;
    div_signed = 1'b0;
    div_valid  = 1'b1;
    @(negedge clk);
    div_valid = 1'b0;
    for (int c = 2; c <= 10; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || quotient !== '0 || remainder !== '0 || div_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid: valid=%b q=%h r=%h ready=%b required 0/0/0/1",
               out_valid, quotient, remainder, div_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(64'd64, 64'd8, 1'b0, q, r, lat, pulses);
    tests++;
    if (q !== 64'd8 || r !== '0 || lat != 65 || pulses != 1) begin
      fails++;
      $display("FAIL after_reset_64_8: q=%0d r=%0d lat=%0d n=%0d required 8/0/65/1",
               q, r, lat, pulses);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] q1, r1, q2, r2;
    int c1, c2, pulses;
    c1     = 0;
    c2     = 0;
    pulses = 0;
    q1     = '0;
    r1     = '0;
    q2     = '0;
    r2     = '0;
    @(negedge clk);
    dividend   = 64'd20;
    divisor    = 64'd6;
    div_signed = 1'b1;
    div_valid  = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (out_valid) begin
        pulses++;
        if (pulses == 1) begin
          c1      = c;
          q1      = quotient;
          r1      = remainder;
          divisor = 64'hFFFF_FFFF_FFFF_FFFA;
        end else if (pulses == 2) begin
          c2        = c;
          q2        = quotient;
          r2        = remainder;
          div_valid = 1'b0;
        end
      end
    end
    div_valid = 1'b0;
    tests++;
    if (pulses != 2 || c1 != 65 || c2 != 131) begin
      fails++;
      $display("FAIL b2b_timing: n=%0d c1=%0d c2=%0d required 2/65/131", pulses, c1, c2);
    end
    tests++;
    if (q1 !== 64'd3 || r1 !== 64'd2 || q2 !== 64'hFFFF_FFFF_FFFF_FFFD || r2 !== 64'd2) begin
      fails++;
      $display("FAIL b2b_results: %h/%h %h/%h required 3/2 fffffffffffffffd/2", q1, r1, q2, r2);
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, q, r, eq, er;
    logic s;
    int lat, pulses, elat;
    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = MinNeg; b = '1; end
        2: b = 64'($urandom_range(1, 50));
        3: begin a = 64'($urandom_range(0, 1000)); b = b >> $urandom_range(0, 63); end
        4: b = {32'hFFFF_FFFF, $urandom};
        default: ;
      endcase
      model(a, b, s, eq, er);
      elat = (b == '0 || (s && a == MinNeg && b == '1)) ? 1 : 65;
      run_op(a, b, s, q, r, lat, pulses);
      tests++;
      if (q !== eq || r !== er || lat != elat || pulses != 1) begin
        fails++;
        $display("FAIL rand%0d s=%0d %h/%h: q=%h r=%h lat=%0d n=%0d required %h/%h/%0d/1",
                 i, s, a, b, q, r, lat, pulses, eq, er, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_timing();
    test_signed_vectors();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
